fp16_int8_acc: RTL and testbench
================================

FP16_INT8_ACC -- requirements
Module: fp16_int8_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 24, meaning the signed accumulator width: sign, 11 integer bits, 12 fraction bits.
REQ-002 SHALL have parameter ACC_INT, default 11, meaning the number of integer bits in the magnitude.
REQ-003 SHALL have ports in this order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts an input element.
- act  in  16  FP16 activation.
- wgt  in  8  INT8 weight, two's complement.
- in_last  in  1  marks the last element of a dot-product group.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream normalizer stage accepts the result.
- out_sign  out  1  result sign.
- out_exp  out  5  biased result exponent.
- out_man  out  ACC_W-1  unsigned magnitude, ACC_INT integer bits; feeds normalizer with EXP_WIDTH=5, MAN_IN_WIDTH=23, INT_LEN=11.
- out_sat  out  1  the group saturated.

Function
REQ-004 SHALL transfer an input on the cycle in_valid and in_ready are both high, and transfer the output on the cycle out_valid and out_ready are both high.
REQ-005 SHALL compute the stall enable en = !out_valid || out_ready, drive in_ready = en, and advance both pipeline stages only when en is high.
REQ-006 Stage S1 SHALL register:
- sign = act[15] XOR wgt[7].
- exp = act[14:10].
- mag = {1, act[9:0]} × |wgt|, 18 bits in 8.10 format.
- last flag.
REQ-007 S1 SHALL treat act exp==0 (zero or subnormal) or wgt==0 as a zero product.
REQ-008 Stage S2 SHALL convert the product to signed ACC_W format by appending 2 fraction zeros and negating when sign=1.
REQ-009 For the first element of a group, S2 SHALL load acc := prod and acc_exp := prod_exp, or acc := 0 and acc_exp := 0 if the product is zero.
REQ-010 For later elements, S2 SHALL align to the larger exponent:
- d = prod_exp − acc_exp.
- d>0: acc >>>= d and acc_exp := prod_exp.
- d<0: prod >>>= −d.
- Shifts ≥ ACC_W yield 0.
- Truncate, no rounding.
REQ-011 S2 SHALL NOT change acc_exp for a zero product unless acc is zero.
REQ-012 S2 SHALL detect signed overflow in the addition, saturate acc to ±(2^(ACC_W−1)−1), and set a sticky sat flag for the group.
REQ-013 The accumulator SHALL also saturate to symmetric bounds, so −2^(ACC_W−1) never occurs.
REQ-014 When the S2 element has last=1, the block SHALL load the output register with:
- out_sign = acc sign.
- out_man = |acc|.
- out_exp = acc_exp.
- out_sat = sat.
It SHALL then assert out_valid and clear the group state (first := 1, sat := 0).
REQ-015 A zero result SHALL output out_sign=0, out_man=0, with out_exp equal to acc_exp.
REQ-016 Latency SHALL be 2 cycles: if the last element is accepted at edge T, out_valid is high after edge T+2.
REQ-017 Throughput SHALL be one element per cycle; back-to-back groups need no bubble.
REQ-018 out_valid and all out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 A single-element group (in_last on the first element) SHALL be legal.

Reset
REQ-020 rst_n low SHALL asynchronously clear:
- out_valid, out_sign, out_exp, out_man, out_sat to 0.
- S1 and S2 valid bits, acc and acc_exp to 0.
- sat to 0; first to 1.
REQ-021 in_ready SHALL be 1 during and after reset.
REQ-022 Reset mid-group SHALL discard the partial sum; the first element after reset starts a new group.

Configuration
REQ-023 Macro FP16_SPECIAL_EN, when defined, SHALL make act exp==31 (Inf/NaN) set a sticky group flag.
REQ-024 With FP16_SPECIAL_EN defined and the flag set, the group result SHALL be out_exp=31, out_man=0, out_sign=sign of the first special product, out_sat=0.
REQ-025 When FP16_SPECIAL_EN is undefined, exp 31 SHALL be treated as an ordinary exponent and the block SHALL contain no special-flag logic.

Structure
REQ-026 Package fp16_int8_pkg SHALL hold FP16_EXP_W=5, FP16_MAN_W=10, INT8_W=8, ACC_W, ACC_INT, and a typedef struct for the S1 product record (sign, exp, mag, last).
REQ-027 Sub-module fp16_int8_mul SHALL implement the combinational product and zero detection.
REQ-028 Alignment, add, saturation and the handshake SHALL reside in fp16_int8_acc.

Verification
REQ-029 act=0x3C00, wgt=3, last=1 -> out_sign=0, out_exp=15, out_man=0x003000, out_sat=0 after 2 cycles.
REQ-030 Group 0x3C00×2 then 0x4000×1, last -> out_exp=16, out_man=0x002000.
REQ-031 0x3C00×−128, last -> out_sign=1, out_exp=15, out_man=0x080000; group 0x3C00×5 then 0x3C00×−5 -> out_man=0, out_sign=0.
REQ-032 Nine elements 0x3FFF×127, last on the ninth -> out_sat=1, out_man=0x7FFFFF, out_sign=0.
REQ-033 Hold out_ready=0 with a result pending -> in_ready=0 and outputs stable for 5 cycles; raise out_ready -> result transfers once and the stream resumes without loss.
REQ-034 With FP16_SPECIAL_EN defined, 0x7C00×1 then 0x3C00×1, last -> out_exp=31, out_man=0; assert rst_n low mid-group -> all outputs 0 and the next group is unaffected.

Source files
------------

// File: rtl/fp16_int8_pkg.sv
// Shared widths, the stage-1 product record and small helpers for the
// FP16 x INT8 dot-product accumulator.
package fp16_int8_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_W     = 1 + FP16_EXP_W + FP16_MAN_W;
    localparam int INT8_W     = 8;
    localparam int ACC_W      = 24;
    localparam int ACC_INT    = 11;

    // {1, mantissa} (1.10) times |wgt| (up to 128) fits in 8.10
    localparam int MAG_W = FP16_MAN_W + 1 + INT8_W - 1;

    localparam logic [FP16_EXP_W-1:0] EXP_SPECIAL = '1;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [MAG_W-1:0]      mag;
        logic                  last;
    } s1_rec_t;

    // Magnitude of a two's-complement INT8; -128 maps to 128 (unsigned)
    function automatic logic [INT8_W-1:0] int8_abs(input logic [INT8_W-1:0] v);
        return v[INT8_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/fp16_int8_mul.sv
// Combinational FP16 x INT8 sign-magnitude product with zero detection.
// Zero or subnormal activations and zero weights produce a zero magnitude.
module fp16_int8_mul
    import fp16_int8_pkg::*;
(
    input  logic [FP16_W-1:0] act,
    input  logic [INT8_W-1:0] wgt,
    input  logic              last,
    output s1_rec_t           prod,
    output logic              zero
);

    logic [FP16_MAN_W:0] sig;
    logic [INT8_W-1:0]   wabs;

    // Form the product record and flag operands that yield a zero product
    always_comb begin
        sig       = {1'b1, act[FP16_MAN_W-1:0]};
        wabs      = int8_abs(wgt);
        zero      = (act[FP16_W-2 -: FP16_EXP_W] == '0) || (wgt == '0);
        prod.sign = act[FP16_W-1] ^ wgt[INT8_W-1];
        prod.exp  = act[FP16_W-2 -: FP16_EXP_W];
        prod.mag  = zero ? '0 : MAG_W'(sig) * MAG_W'(wabs);
        prod.last = last;
    end

endmodule

// File: rtl/fp16_int8_acc.sv
// FP16 activation x INT8 weight dot-product accumulator.
// Pipeline: S1 product register, S2 signed/converted product register,
// then the group accumulator and output register (2-cycle latency).
// Optional macro FP16_SPECIAL_EN: exponent 31 inputs mark the group as
// Inf/NaN and force an exp=31, man=0 result.
module fp16_int8_acc
    import fp16_int8_pkg::*;
#(
    parameter int ACC_W   = fp16_int8_pkg::ACC_W,
    parameter int ACC_INT = fp16_int8_pkg::ACC_INT
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FP16_W-1:0]     act,
    input  logic [INT8_W-1:0]     wgt,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [FP16_EXP_W-1:0] out_exp,
    output logic [ACC_W-2:0]      out_man,
    output logic                  out_sat
);

    // Fraction zeros appended to the 8.10 product to reach the accumulator fraction
    localparam int PAD = ACC_W - 1 - ACC_INT - FP16_MAN_W;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

    // Arithmetic right shift where shifts past the width flush to zero
    function automatic acc_t asr_clip(input acc_t v, input logic [FP16_EXP_W:0] sh);
        acc_t r;
        if (int'(sh) >= ACC_W) begin
            r = '0;
        end else begin
            r = v >>> sh;
        end
        return r;
    endfunction

    logic en;

    s1_rec_t mul_rec;
    logic    mul_zero;

    logic    s1_valid_q, s1_valid_d;
    s1_rec_t s1_q, s1_d;
    logic    s1_zero_q, s1_zero_d;

    logic                  s2_valid_q, s2_valid_d;
    acc_t                  s2_prod_q, s2_prod_d;
    logic [FP16_EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic                  s2_zero_q, s2_zero_d;
    logic                  s2_last_q, s2_last_d;

    acc_t                  acc_q, acc_d;
    logic [FP16_EXP_W-1:0] acc_exp_q, acc_exp_d;
    logic                  first_q, first_d;
    logic                  sat_q, sat_d;

    logic                  out_valid_q, out_valid_d;
    logic                  out_sign_q, out_sign_d;
    logic [FP16_EXP_W-1:0] out_exp_q, out_exp_d;
    logic [ACC_W-2:0]      out_man_q, out_man_d;
    logic                  out_sat_q, out_sat_d;

    acc_t                    prod_ext;
    acc_t                    aln_acc, aln_prod;
    logic signed [ACC_W:0]   sum;
    logic signed [FP16_EXP_W:0] diff;
    acc_t                    grp_acc;
    logic [FP16_EXP_W-1:0]   grp_exp;
    logic                    grp_sat;

`ifdef FP16_SPECIAL_EN
    logic s2_sign_q, s2_sign_d;
    logic spec_q, spec_d;
    logic spec_sign_q, spec_sign_d;
    logic grp_spec, grp_spec_sign;
`endif

    fp16_int8_mul u_mul (
        .act  (act),
        .wgt  (wgt),
        .last (in_last),
        .prod (mul_rec),
        .zero (mul_zero)
    );

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_man   = out_man_q;
    assign out_sat   = out_sat_q;

    // Compute the group sum after folding in the S2 product (aligned, saturated)
    always_comb begin
        prod_ext = acc_t'({s1_q.mag, {PAD{1'b0}}});
        diff     = $signed({1'b0, s2_exp_q}) - $signed({1'b0, acc_exp_q});
        aln_acc  = acc_q;
        aln_prod = s2_prod_q;
        sum      = '0;
        grp_acc  = acc_q;
        grp_exp  = acc_exp_q;
        grp_sat  = sat_q;
        if (first_q) begin
            grp_sat = 1'b0;
            if (s2_zero_q) begin
                grp_acc = '0;
                grp_exp = '0;
            end else begin
                grp_acc = s2_prod_q;
                grp_exp = s2_exp_q;
            end
        end else if (!s2_zero_q) begin
            if (diff > 0) begin
                aln_acc = asr_clip(acc_q, (FP16_EXP_W+1)'(diff));
                grp_exp = s2_exp_q;
            end else if (diff < 0) begin
                aln_prod = asr_clip(s2_prod_q, (FP16_EXP_W+1)'(-diff));
            end
            sum = {aln_acc[ACC_W-1], aln_acc} + {aln_prod[ACC_W-1], aln_prod};
            if (sum > SUM_MAX) begin
                grp_acc = ACC_MAX;
                grp_sat = 1'b1;
            end else if (sum < SUM_MIN) begin
                grp_acc = ACC_MIN;
                grp_sat = 1'b1;
            end else begin
                grp_acc = sum[ACC_W-1:0];
            end
        end
`ifdef FP16_SPECIAL_EN
        grp_spec      = first_q ? 1'b0 : spec_q;
        grp_spec_sign = first_q ? 1'b0 : spec_sign_q;
        if ((s2_exp_q == EXP_SPECIAL) && !grp_spec) begin
            grp_spec      = 1'b1;
            grp_spec_sign = s2_sign_q;
        end
`endif
    end

    // Next-state for both pipeline stages, group state and output register
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        s1_zero_d   = s1_zero_q;
        s2_valid_d  = s2_valid_q;
        s2_prod_d   = s2_prod_q;
        s2_exp_d    = s2_exp_q;
        s2_zero_d   = s2_zero_q;
        s2_last_d   = s2_last_q;
        acc_d       = acc_q;
        acc_exp_d   = acc_exp_q;
        first_d     = first_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_man_d   = out_man_q;
        out_sat_d   = out_sat_q;
`ifdef FP16_SPECIAL_EN
        s2_sign_d   = s2_sign_q;
        spec_d      = spec_q;
        spec_sign_d = spec_sign_q;
`endif
        if (en) begin
            s1_valid_d  = in_valid;
            s1_d        = mul_rec;
            s1_zero_d   = mul_zero;
            s2_valid_d  = s1_valid_q;
            s2_prod_d   = s1_q.sign ? -prod_ext : prod_ext;
            s2_exp_d    = s1_q.exp;
            s2_zero_d   = s1_zero_q;
            s2_last_d   = s1_q.last;
`ifdef FP16_SPECIAL_EN
            s2_sign_d   = s1_q.sign;
`endif
            out_valid_d = 1'b0;
            if (s2_valid_q) begin
                if (s2_last_q) begin
                    out_valid_d = 1'b1;
                    out_sign_d  = grp_acc[ACC_W-1];
                    out_man_d   = grp_acc[ACC_W-1] ? (ACC_W-1)'(-grp_acc)
                                                   : grp_acc[ACC_W-2:0];
                    out_exp_d   = grp_exp;
                    out_sat_d   = grp_sat;
`ifdef FP16_SPECIAL_EN
                    if (grp_spec) begin
                        out_sign_d = grp_spec_sign;
                        out_exp_d  = EXP_SPECIAL;
                        out_man_d  = '0;
                        out_sat_d  = 1'b0;
                    end
                    spec_d      = 1'b0;
                    spec_sign_d = 1'b0;
`endif
                    acc_d     = '0;
                    acc_exp_d = '0;
                    first_d   = 1'b1;
                    sat_d     = 1'b0;
                end else begin
                    acc_d     = grp_acc;
                    acc_exp_d = grp_exp;
                    first_d   = 1'b0;
                    sat_d     = grp_sat;
`ifdef FP16_SPECIAL_EN
                    spec_d      = grp_spec;
                    spec_sign_d = grp_spec_sign;
`endif
                end
            end
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            s1_zero_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '0;
            s2_exp_q    <= '0;
            s2_zero_q   <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            acc_exp_q   <= '0;
            first_q     <= 1'b1;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_man_q   <= '0;
            out_sat_q   <= 1'b0;
`ifdef FP16_SPECIAL_EN
            s2_sign_q   <= 1'b0;
            spec_q      <= 1'b0;
            spec_sign_q <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            s1_zero_q   <= s1_zero_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_exp_q    <= s2_exp_d;
            s2_zero_q   <= s2_zero_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            acc_exp_q   <= acc_exp_d;
            first_q     <= first_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_man_q   <= out_man_d;
            out_sat_q   <= out_sat_d;
`ifdef FP16_SPECIAL_EN
            s2_sign_q   <= s2_sign_d;
            spec_q      <= spec_d;
            spec_sign_q <= spec_sign_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp16_int8_acc.sv
// Directed self-checking bench for fp16_int8_acc.
module tb_fp16_int8_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] act;
    logic [7:0]  wgt;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [4:0]  out_exp;
    logic [22:0] out_man;
    logic        out_sat;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    fp16_int8_acc #(
        .ACC_W   (24),
        .ACC_INT (11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act       (act),
        .wgt       (wgt),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_man   (out_man),
        .out_sat   (out_sat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one element and hold it until accepted (bounded)
    task automatic send(input logic [15:0] a, input logic [7:0] w, input logic l);
        bit ok;
        ok       = 1'b0;
        act      = a;
        wgt      = w;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Wait for the group result after the last element was accepted
    task automatic expect_result(input string tag, input logic s, input logic [4:0] e,
                                 input logic [22:0] m, input logic sat);
        int cnt;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!out_valid && cnt < 8);
        chk({tag, ".lat"},  cnt,      32'd2);
        chk({tag, ".sign"}, out_sign, s);
        chk({tag, ".exp"},  out_exp,  e);
        chk({tag, ".man"},  out_man,  m);
        chk({tag, ".sat"},  out_sat,  sat);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        act       = '0;
        wgt       = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("rst.in_ready",  in_ready,  1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_man",   out_man,   0);
        chk("rst.out_exp",   out_exp,   0);
        chk("rst.out_sign",  out_sign,  0);
        chk("rst.out_sat",   out_sat,   0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst.in_ready", in_ready, 1);

        send(16'h3C00, 8'd3, 1'b1);
        expect_result("one_x3", 1'b0, 5'd15, 23'h003000, 1'b0);

        send(16'h3C00, 8'd2, 1'b0);
        send(16'h4000, 8'd1, 1'b1);
        expect_result("align_up", 1'b0, 5'd16, 23'h002000, 1'b0);

        send(16'h3C00, 8'h80, 1'b1);
        expect_result("neg128", 1'b1, 5'd15, 23'h080000, 1'b0);

        send(16'h3C00, 8'd5, 1'b0);
        send(16'h3C00, 8'hFB, 1'b1);
        expect_result("cancel", 1'b0, 5'd15, 23'h000000, 1'b0);

        send(16'h4000, 8'd1, 1'b0);
        send(16'h3C00, 8'd1, 1'b1);
        expect_result("align_dn", 1'b0, 5'd16, 23'h001800, 1'b0);

        send(16'h3C00, 8'hFD, 1'b0);
        send(16'h3C00, 8'd1, 1'b1);
        expect_result("mixed", 1'b1, 5'd15, 23'h002000, 1'b0);

        send(16'h0000, 8'd5, 1'b0);
        send(16'h0001, 8'd5, 1'b1);
        expect_result("zeros", 1'b0, 5'd0, 23'h000000, 1'b0);

        send(16'h3C00, 8'd0, 1'b0);
        send(16'h3C00, 8'd3, 1'b1);
        expect_result("zero_first", 1'b0, 5'd15, 23'h003000, 1'b0);

        send(16'h7800, 8'd1, 1'b0);
        send(16'h0400, 8'd1, 1'b1);
        expect_result("far_shift", 1'b0, 5'd30, 23'h001000, 1'b0);

        for (int i = 0; i < 9; i++) send(16'h3FFF, 8'd127, i == 8);
        expect_result("sat_pos", 1'b0, 5'd15, 23'h7FFFFF, 1'b1);

        for (int i = 0; i < 9; i++) send(16'h3FFF, 8'h81, i == 8);
        expect_result("sat_neg", 1'b1, 5'd15, 23'h7FFFFF, 1'b1);

        send(16'h3C00, 8'd3, 1'b1);
        expect_result("sat_clear", 1'b0, 5'd15, 23'h003000, 1'b0);

        // Back-to-back single-element groups
        send(16'h3C00, 8'd1, 1'b1);
        send(16'h3C00, 8'd2, 1'b1);
        @(posedge clk); #1;
        chk("b2b.v0", out_valid, 1);
        chk("b2b.m0", out_man, 23'h001000);
        @(posedge clk); #1;
        chk("b2b.v1", out_valid, 1);
        chk("b2b.m1", out_man, 23'h002000);
        @(posedge clk); #1;
        chk("b2b.idle", out_valid, 0);

        // Backpressure: result held, input stalls, nothing lost on release
        out_ready = 1'b0;
        send(16'h3C00, 8'd3, 1'b1);
        send(16'h4000, 8'd2, 1'b1);
        send(16'h3C00, 8'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall.valid", out_valid, 1);
            chk("stall.ready", in_ready,  0);
            chk("stall.man",   out_man,   23'h003000);
            chk("stall.exp",   out_exp,   5'd15);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("resume.v1",   out_valid, 1);
        chk("resume.man1", out_man,   23'h002000);
        chk("resume.exp1", out_exp,   5'd16);
        @(posedge clk); #1;
        chk("resume.v2",   out_valid, 1);
        chk("resume.man2", out_man,   23'h001000);
        chk("resume.exp2", out_exp,   5'd15);
        @(posedge clk); #1;
        chk("resume.idle", out_valid, 0);

`ifdef FP16_SPECIAL_EN
        send(16'h7C00, 8'd1, 1'b0);
        send(16'h3C00, 8'd1, 1'b1);
        expect_result("special", 1'b0, 5'd31, 23'h000000, 1'b0);
`else
        send(16'h7C00, 8'd1, 1'b1);
        expect_result("exp31", 1'b0, 5'd31, 23'h001000, 1'b0);
`endif

        // Reset in the middle of a group discards the partial sum
        send(16'h7C00, 8'd1, 1'b0);
        send(16'h3C00, 8'd2, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst.in_ready",  in_ready,  1);
        chk("mid_rst.out_valid", out_valid, 0);
        chk("mid_rst.out_man",   out_man,   0);
        chk("mid_rst.out_exp",   out_exp,   0);
        chk("mid_rst.out_sign",  out_sign,  0);
        chk("mid_rst.out_sat",   out_sat,   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(16'h3C00, 8'd3, 1'b1);
        expect_result("after_rst", 1'b0, 5'd15, 23'h003000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
